// File: rtl/lzc_stream.sv
// Streaming leading/trailing zero counter with a rotating start offset.
// Stage 1 rotates the search so the start bit sits at position 0; stage 2 finds the first one.
module lzc_stream #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          PIPE_REG  = 1'b1,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 mode_i,
  input  logic [CNT_WIDTH-1:0] offset_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [CNT_WIDTH-1:0] index_o,
  output logic                 empty_o
);

  localparam logic [CNT_WIDTH:0]   WidthL = (CNT_WIDTH + 1)'(WIDTH);
  localparam logic [CNT_WIDTH-1:0] LastL  = CNT_WIDTH'(WIDTH - 1);

  // (a + b) mod WIDTH, or (a - b) mod WIDTH when sub is set; a, b < WIDTH.
  function automatic logic [CNT_WIDTH-1:0] mod_step(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b,
                                                    input logic                 sub);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + (sub ? (WidthL - {1'b0, b}) : {1'b0, b});
    if (sum >= WidthL) sum = sum - WidthL;
    return sum[CNT_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH-1:0] w_off_eff;
  logic [CNT_WIDTH-1:0] w_start;
  logic [WIDTH-1:0]     w_rot;

  always_comb begin
    w_off_eff = ({1'b0, offset_i} >= WidthL) ? '0 : offset_i;
    w_start   = mode_i ? (LastL - w_off_eff) : w_off_eff;
    w_rot     = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_rot[k] = data_i[mod_step(w_start, CNT_WIDTH'(k), mode_i)];
    end
  end

  logic                 w_s2_valid;
  logic [WIDTH-1:0]     w_s2_vec;
  logic [CNT_WIDTH-1:0] w_s2_start;
  logic                 w_s2_mode;
  logic                 w_out_ready;
  logic                 w_load;
  logic                 r_out_valid;

  assign w_out_ready = ~r_out_valid | ready_i;
  assign w_load      = w_s2_valid & w_out_ready;

  if (PIPE_REG) begin : g_pipe
    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_vec;
    logic [CNT_WIDTH-1:0] r_s1_start;
    logic                 r_s1_mode;
    logic                 w_s1_accept;

    assign ready_o     = ~clr_i & (~r_s1_valid | w_out_ready);
    assign w_s1_accept = valid_i & ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_s1_valid <= 1'b0;
      end else if (clr_i) begin
        r_s1_valid <= 1'b0;
      end else if (w_s1_accept) begin
        r_s1_valid <= 1'b1;
      end else if (w_out_ready) begin
        r_s1_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_s1_vec   <= '0;
        r_s1_start <= '0;
        r_s1_mode  <= 1'b0;
      end else if (w_s1_accept) begin
        r_s1_vec   <= w_rot;
        r_s1_start <= w_start;
        r_s1_mode  <= mode_i;
      end
    end

    assign w_s2_valid = r_s1_valid;
    assign w_s2_vec   = r_s1_vec;
    assign w_s2_start = r_s1_start;
    assign w_s2_mode  = r_s1_mode;
  end else begin : g_comb
    assign ready_o    = ~clr_i & w_out_ready;
    assign w_s2_valid = valid_i & ~clr_i;
    assign w_s2_vec   = w_rot;
    assign w_s2_start = w_start;
    assign w_s2_mode  = mode_i;
  end

  logic [CNT_WIDTH-1:0] w_cnt;
  logic [CNT_WIDTH-1:0] w_index;
  logic                 w_empty;

  // Lowest set bit of the rotated vector is the distance from the start bit.
  always_comb begin
    w_cnt = LastL;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (w_s2_vec[k]) w_cnt = CNT_WIDTH'(k);
    end
    w_empty = ~|w_s2_vec;
    w_index = w_empty ? w_s2_start : mod_step(w_s2_start, w_cnt, w_s2_mode);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
    end else if (clr_i) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
    end else if (ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o   <= '0;
      index_o <= '0;
      empty_o <= 1'b0;
    end else if (w_load) begin
      cnt_o   <= w_cnt;
      index_o <= w_index;
      empty_o <= w_empty;
    end
  end

  assign valid_o = r_out_valid;

endmodule

// File: tb/tb_lzc_stream.sv
// Bench for lzc_stream: directed scenarios plus randomized traffic against a visit-order model.
// Three instances share stimulus: WIDTH=8 pipelined, WIDTH=8 unpipelined, WIDTH=6 pipelined.
module tb_lzc_stream;

  logic       clk = 1'b0;
  logic       rst_n, clr, valid, mode, ready;
  logic [7:0] data;
  logic [2:0] off;

  logic       rdy8, v8, e8, rdy0, v0, e0, rdy6, v6, e6;
  logic [2:0] c8, i8, c0, i0, c6, i6;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] cnt;
    logic [2:0] idx;
    logic       emp;
  } exp_t;

  always #5 clk = ~clk;

  lzc_stream #(.WIDTH(8), .PIPE_REG(1'b1)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(valid), .ready_o(rdy8),
    .data_i(data), .mode_i(mode), .offset_i(off), .valid_o(v8), .ready_i(ready),
    .cnt_o(c8), .index_o(i8), .empty_o(e8)
  );

  lzc_stream #(.WIDTH(8), .PIPE_REG(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(valid), .ready_o(rdy0),
    .data_i(data), .mode_i(mode), .offset_i(off), .valid_o(v0), .ready_i(ready),
    .cnt_o(c0), .index_o(i0), .empty_o(e0)
  );

  lzc_stream #(.WIDTH(6), .PIPE_REG(1'b1)) u_dut6 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(valid), .ready_o(rdy6),
    .data_i(data[5:0]), .mode_i(mode), .offset_i(off), .valid_o(v6), .ready_i(ready),
    .cnt_o(c6), .index_o(i6), .empty_o(e6)
  );

  // Walk the bits in visit order from the start bit; first set bit wins.
  function automatic exp_t model(input int w, input logic [7:0] d, input logic m, input int o);
    exp_t r;
    int   s, p, oe;
    bit   found;
    oe    = (o >= w) ? 0 : o;
    s     = m ? (w - 1 - oe) : oe;
    r     = '{cnt: 3'(w - 1), idx: 3'(s), emp: 1'b1};
    found = 1'b0;
    for (int k = 0; k < w; k++) begin
      p = m ? ((s - k + w) % w) : ((s + k) % w);
      if (!found && d[p]) begin
        r     = '{cnt: 3'(k), idx: 3'(p), emp: 1'b0};
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic flush();
    @(negedge clk);
    valid = 1'b0;
    clr   = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; valid = 1'b0; ready = 1'b1;
    mode  = 1'b0; off = '0;   data  = '0;
    #12;
    checks++;
    if ({v8, c8, i8, e8} !== 8'b0) begin
      errors++; $display("FAIL reset_dut8 got %b want 00000000", {v8, c8, i8, e8});
    end
    checks++;
    if ({v0, c0, i0, e0, v6} !== 9'b0) begin
      errors++; $display("FAIL reset_others got %b want 000000000", {v0, c0, i0, e0, v6});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_beat(input string name, input logic m, input logic [2:0] o,
                                  input logic [7:0] d, input exp_t e);
    @(negedge clk);
    valid = 1'b1; mode = m; off = o; data = d; ready = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if ({v0, c0, i0, e0} !== {1'b1, e}) begin
      errors++; $display("FAIL %s_lat1 got %b want %b", name, {v0, c0, i0, e0}, {1'b1, e});
    end
    checks++;
    if (v8 !== 1'b0) begin
      errors++; $display("FAIL %s_early got valid %b want 0", name, v8);
    end
    @(negedge clk);
    checks++;
    if ({v8, c8, i8, e8} !== {1'b1, e}) begin
      errors++; $display("FAIL %s_lat2 got %b want %b", name, {v8, c8, i8, e8}, {1'b1, e});
    end
  endtask

  task automatic test_offset_clamp();
    logic       m[3]  = '{1'b0, 1'b1, 1'b1};
    logic [2:0] o[3]  = '{3'd7, 3'd6, 3'd7};
    logic [7:0] d[3]  = '{8'h02, 8'h20, 8'h01};
    exp_t       e[3]  = '{'{3'd1, 3'd1, 1'b0}, '{3'd0, 3'd5, 1'b0}, '{3'd5, 3'd0, 1'b0}};
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      valid = 1'b1; mode = m[t]; off = o[t]; data = d[t]; ready = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({v6, c6, i6, e6} !== {1'b1, e[t]}) begin
        errors++; $display("FAIL clamp_w6_%0d got %b want %b", t, {v6, c6, i6, e6}, {1'b1, e[t]});
      end
    end
  endtask

  task automatic test_backpressure();
    flush();
    @(negedge clk);
    ready = 1'b0; valid = 1'b1; mode = 1'b0; off = '0; data = 8'h01;
    #1; checks++;
    if (rdy8 !== 1'b1) begin errors++; $display("FAIL bp_accept_a got %b want 1", rdy8); end
    @(negedge clk);
    data = 8'h10;
    #1; checks++;
    if (rdy8 !== 1'b1) begin errors++; $display("FAIL bp_accept_b got %b want 1", rdy8); end
    @(negedge clk);
    data = 8'h00;
    for (int h = 0; h < 3; h++) begin
      #1; checks++;
      if ({rdy8, v8, c8, i8, e8} !== 9'b0_1_000_000_0) begin
        errors++;
        $display("FAIL bp_hold_%0d got %b want 010000000", h, {rdy8, v8, c8, i8, e8});
      end
      @(negedge clk);
    end
    ready = 1'b1;
    #1; checks++;
    if (rdy8 !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", rdy8); end
    @(negedge clk);
    valid = 1'b0;
    #1; checks++;
    if ({v8, c8, i8, e8} !== 8'b1_100_100_0) begin
      errors++; $display("FAIL bp_beat_b got %b want 11001000", {v8, c8, i8, e8});
    end
    @(negedge clk);
    #1; checks++;
    if ({v8, c8, i8, e8} !== 8'b1_111_000_1) begin
      errors++; $display("FAIL bp_beat_c got %b want 11110001", {v8, c8, i8, e8});
    end
    @(negedge clk);
    #1; checks++;
    if (v8 !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", v8); end
  endtask

  task automatic test_clear();
    flush();
    @(negedge clk);
    valid = 1'b1; mode = 1'b0; off = '0; data = 8'h04; ready = 1'b1;
    @(negedge clk);
    data = 8'h40;
    @(negedge clk);
    clr = 1'b1; data = 8'h02;
    #1; checks++;
    if ({rdy8, rdy0, rdy6} !== 3'b000) begin
      errors++; $display("FAIL clr_ready got %b want 000", {rdy8, rdy0, rdy6});
    end
    @(negedge clk);
    clr = 1'b0; valid = 1'b0;
    for (int h = 0; h < 4; h++) begin
      #1; checks++;
      if ({v8, v0, v6} !== 3'b000) begin
        errors++; $display("FAIL clr_flush_%0d got %b want 000", h, {v8, v0, v6});
      end
      @(negedge clk);
    end
    valid = 1'b1; data = 8'h20;
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (v8 !== 1'b0) begin errors++; $display("FAIL clr_next_early got %b want 0", v8); end
    @(negedge clk);
    checks++;
    if ({v8, c8, i8, e8} !== 8'b1_101_101_0) begin
      errors++; $display("FAIL clr_next_beat got %b want 11011010", {v8, c8, i8, e8});
    end
  endtask

  task automatic test_async_reset();
    flush();
    @(negedge clk);
    valid = 1'b1; mode = 1'b0; off = '0; data = 8'h80; ready = 1'b0;
    @(negedge clk);
    data = 8'h40;
    @(negedge clk);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1; checks++;
    if ({v8, c8, i8, e8, v0, c0, i0} !== 15'b0) begin
      errors++; $display("FAIL arst_clear got %b want 0", {v8, c8, i8, e8, v0, c0, i0});
    end
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      checks++;
      if ({v8, v0, v6} !== 3'b000) begin
        errors++; $display("FAIL arst_quiet_%0d got %b want 000", h, {v8, v0, v6});
      end
    end
  endtask

  task automatic test_random();
    exp_t q8[$], q0[$], q6[$];
    int   sel;
    flush();
    for (int cyc = 0; cyc < 808; cyc++) begin
      @(negedge clk);
      if (cyc < 800) begin
        valid = ($urandom_range(0, 9) < 7);
        mode  = 1'($urandom);
        off   = 3'($urandom);
        sel   = $urandom_range(0, 3);
        data  = (sel == 0) ? 8'h00 : (sel == 1) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
        ready = ($urandom_range(0, 9) < 7);
      end else begin
        valid = 1'b0;
        ready = 1'b1;
      end
      #1;
      if (v8 && ready) begin
        checks++;
        if (q8.size() == 0) begin
          errors++; $display("FAIL rand_dut8_extra got %b want no beat", {c8, i8, e8});
        end else begin
          if ({c8, i8, e8} !== q8[0]) begin
            errors++; $display("FAIL rand_dut8 got %b want %b", {c8, i8, e8}, q8[0]);
          end
          void'(q8.pop_front());
        end
      end
      if (v0 && ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL rand_dut0_extra got %b want no beat", {c0, i0, e0});
        end else begin
          if ({c0, i0, e0} !== q0[0]) begin
            errors++; $display("FAIL rand_dut0 got %b want %b", {c0, i0, e0}, q0[0]);
          end
          void'(q0.pop_front());
        end
      end
      if (v6 && ready) begin
        checks++;
        if (q6.size() == 0) begin
          errors++; $display("FAIL rand_dut6_extra got %b want no beat", {c6, i6, e6});
        end else begin
          if ({c6, i6, e6} !== q6[0]) begin
            errors++; $display("FAIL rand_dut6 got %b want %b", {c6, i6, e6}, q6[0]);
          end
          void'(q6.pop_front());
        end
      end
      if (valid && rdy8) q8.push_back(model(8, data, mode, int'(off)));
      if (valid && rdy0) q0.push_back(model(8, data, mode, int'(off)));
      if (valid && rdy6) q6.push_back(model(6, data & 8'h3f, mode, int'(off)));
    end
    checks++;
    if (q8.size() + q0.size() + q6.size() != 0) begin
      errors++;
      $display("FAIL rand_lost_beats got %0d pending want 0", q8.size() + q0.size() + q6.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_beat("trail_off0", 1'b0, 3'd0, 8'h08, '{3'd3, 3'd3, 1'b0});
    test_single_beat("trail_wrap", 1'b0, 3'd5, 8'h09, '{3'd3, 3'd0, 1'b0});
    test_single_beat("lead_wrap",  1'b1, 3'd2, 8'h80, '{3'd6, 3'd7, 1'b0});
    test_single_beat("lead_empty", 1'b1, 3'd0, 8'h00, '{3'd7, 3'd7, 1'b1});
    test_offset_clamp();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
